pipe_ctrl: RTL

- Pipelined control unit for the 5-stage MIPS core.
- Decodes the ID-stage opcode and carries the control word through the ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use and branch-operand hazards, inserting bubbles and holding PC and IF/ID.
- Resolves branches and jumps in ID with an IF flush, and keeps saturating stall/flush performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 60 ++++++
 rtl/pipe_ctrl_decode.sv | 86 ++++++++
 rtl/pipe_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared definitions for the pipelined MIPS control unit: opcode values,
// PC-source / destination-select / ALU-class codes and the decoded control
// word carried from ID into the pipeline registers.
// No ports (package).

package pipe_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] DST_RT  = 2'b00;
    localparam logic [1:0] DST_RD  = 2'b01;
    localparam logic [1:0] DST_R31 = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // Fields that travel down the pipeline past ID.
    typedef struct packed {
        logic       imm_command;
        logic       alu_src_b;
        logic [1:0] dst_sel;
        logic [1:0] alu_op;
        logic       link;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
    } ex_ctrl_t;

    // Full ID decode: ID-only steering bits plus the travelling part.
    typedef struct packed {
        logic     is_beq;
        logic     is_bne;
        logic     is_jump;
        logic     rt_is_source;
        ex_ctrl_t ex;
    } ctrl_t;

    function automatic logic is_branch(input ctrl_t c);
        return c.is_beq | c.is_bne;
    endfunction

endpackage

// File: rtl/pipe_ctrl_decode.sv
// ctrl_decode
// Pure combinational opcode decoder. Unsupported opcodes (including BNE/JAL
// when disabled) produce an all-zero control word and raise illegal.
// Ports:
//   opcode  in   6-bit ID-stage opcode
//   ctrl    out  decoded control word
//   illegal out  opcode is not supported (not gated by any valid)

module ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter bit EN_BNE = 1'b1,
    parameter bit EN_JAL = 1'b1
) (
    input  logic [5:0] opcode,
    output ctrl_t      ctrl,
    output logic       illegal
);

    always_comb begin
        ctrl    = '0;
        illegal = 1'b0;
        case (opcode)
            OP_LW: begin
                ctrl.ex.alu_op     = ALU_ADD;
                ctrl.ex.alu_src_b  = 1'b1;
                ctrl.ex.dst_sel    = DST_RT;
                ctrl.ex.mem_read   = 1'b1;
                ctrl.ex.mem_to_reg = 1'b1;
                ctrl.ex.reg_write  = 1'b1;
            end
            OP_SW: begin
                ctrl.ex.alu_op    = ALU_ADD;
                ctrl.ex.alu_src_b = 1'b1;
                ctrl.ex.dst_sel   = DST_RT;
                ctrl.ex.mem_write = 1'b1;
                ctrl.rt_is_source = 1'b1;
            end
            OP_RTYPE: begin
                ctrl.ex.alu_op    = ALU_FUNCT;
                ctrl.ex.dst_sel   = DST_RD;
                ctrl.ex.reg_write = 1'b1;
                ctrl.rt_is_source = 1'b1;
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: begin
                ctrl.ex.imm_command = 1'b1;
                ctrl.ex.alu_src_b   = 1'b1;
                ctrl.ex.alu_op      = ALU_FUNCT;
                ctrl.ex.dst_sel     = DST_RT;
                ctrl.ex.reg_write   = 1'b1;
            end
            OP_BEQ: begin
                ctrl.is_beq       = 1'b1;
                ctrl.ex.alu_op    = ALU_SUB;
                ctrl.rt_is_source = 1'b1;
            end
            OP_BNE: begin
                if (EN_BNE) begin
                    ctrl.is_bne       = 1'b1;
                    ctrl.ex.alu_op    = ALU_SUB;
                    ctrl.rt_is_source = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_J: begin
                ctrl.is_jump = 1'b1;
            end
            OP_JAL: begin
                if (EN_JAL) begin
                    ctrl.is_jump      = 1'b1;
                    ctrl.ex.alu_op    = ALU_ADD;
                    ctrl.ex.dst_sel   = DST_R31;
                    ctrl.ex.link      = 1'b1;
                    ctrl.ex.reg_write = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
// Control unit for the 5-stage MIPS pipeline. Decodes the ID opcode, carries
// the control word through ID/EX, EX/MEM and MEM/WB, detects load-use and
// branch-operand hazards, resolves branches/jumps in ID and keeps saturating
// stall/flush counters.
// Ports:
//   clk, rst_n              core clock, async active-low reset
//   id_valid, opcode        ID instruction present / its opcode
//   id_rs, id_rt, id_rd     ID register addresses
//   branch_eq               ID comparator result (rs == rt)
//   ext_stall               memory wait, freezes everything
//   pc_write, if_id_write   front-end enables
//   if_flush, if_pc_source  redirect squash / next-PC select
//   id_rt_is_source         rt is read as an operand
//   id_illegal              unsupported opcode in ID
//   ex_*                    EX-stage control
//   mem_read, mem_write     MEM-stage control
//   wb_mem_to_reg, wb_reg_write  WB-stage control
//   stall_cnt, flush_cnt    saturating performance counters

module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int RA_W     = 5,
    parameter int ALU_OP_W = 2,
    parameter int CNT_W    = 16,
    parameter bit EN_BNE   = 1'b1,
    parameter bit EN_JAL   = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [5:0]          opcode,
    input  logic [RA_W-1:0]     id_rs,
    input  logic [RA_W-1:0]     id_rt,
    input  logic [RA_W-1:0]     id_rd,
    input  logic                branch_eq,
    input  logic                ext_stall,
    output logic                pc_write,
    output logic                if_id_write,
    output logic                if_flush,
    output logic [1:0]          if_pc_source,
    output logic                id_rt_is_source,
    output logic                id_illegal,
    output logic                ex_valid,
    output logic                ex_imm_command,
    output logic                ex_alu_src_b,
    output logic [1:0]          ex_dst_reg_sel,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic                ex_link,
    output logic                mem_read,
    output logic                mem_write,
    output logic                wb_mem_to_reg,
    output logic                wb_reg_write,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    flush_cnt
);

    ctrl_t           w_dec_ctrl;
    logic            w_dec_illegal;
    ctrl_t           w_id_ctrl;
    logic [RA_W-1:0] w_id_dst;
    logic            w_is_br;
    logic            w_ex_hit;
    logic            w_mem_hit;
    logic            w_hz;
    logic            w_taken_br;
    logic            w_redirect;

    ex_ctrl_t        r_ex;
    logic            r_ex_valid;
    logic [RA_W-1:0] r_ex_dst;
    logic            r_mem_read;
    logic            r_mem_write;
    logic            r_mem_to_reg;
    logic            r_mem_reg_write;
    logic [RA_W-1:0] r_mem_dst;
    logic            r_wb_mem_to_reg;
    logic            r_wb_reg_write;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    ctrl_decode #(
        .EN_BNE (EN_BNE),
        .EN_JAL (EN_JAL)
    ) u_decode (
        .opcode  (opcode),
        .ctrl    (w_dec_ctrl),
        .illegal (w_dec_illegal)
    );

    // Illegal opcodes already decode to zero; only id_valid needs gating.
    assign w_id_ctrl = id_valid ? w_dec_ctrl : '0;

    always_comb begin
        case (w_id_ctrl.ex.dst_sel)
            DST_RD:  w_id_dst = id_rd;
            DST_R31: w_id_dst = RA_W'(31);
            default: w_id_dst = id_rt;
        endcase
    end

    // A tagged destination matches when it is non-zero and equals rs, or
    // equals rt for instructions that actually read rt.
    assign w_ex_hit  = (r_ex_dst != '0) &&
                       ((r_ex_dst == id_rs) || (w_dec_ctrl.rt_is_source && (r_ex_dst == id_rt)));
    assign w_mem_hit = (r_mem_dst != '0) &&
                       ((r_mem_dst == id_rs) || (w_dec_ctrl.rt_is_source && (r_mem_dst == id_rt)));

    assign w_is_br = is_branch(w_id_ctrl);

    assign w_hz = id_valid &
                  ((r_ex_valid & r_ex.mem_read & w_ex_hit) |
                   (w_is_br & r_ex.reg_write & w_ex_hit) |
                   (w_is_br & r_mem_read & w_mem_hit));

    assign w_taken_br = (w_id_ctrl.is_beq & branch_eq) | (w_id_ctrl.is_bne & ~branch_eq);
    assign w_redirect = ~ext_stall & ~w_hz & (w_taken_br | w_id_ctrl.is_jump);

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_flush     = 1'b0;
        if_pc_source = PC_SRC_SEQ;
        if (ext_stall || w_hz) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (w_redirect) begin
            if_flush     = 1'b1;
            if_pc_source = w_id_ctrl.is_jump ? PC_SRC_JUMP : PC_SRC_BRANCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex            <= '0;
            r_ex_valid      <= 1'b0;
            r_ex_dst        <= '0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_mem_to_reg    <= 1'b0;
            r_mem_reg_write <= 1'b0;
            r_mem_dst       <= '0;
            r_wb_mem_to_reg <= 1'b0;
            r_wb_reg_write  <= 1'b0;
        end else if (!ext_stall) begin
            if (w_hz) begin
                r_ex       <= '0;
                r_ex_valid <= 1'b0;
                r_ex_dst   <= '0;
            end else begin
                r_ex       <= w_id_ctrl.ex;
                r_ex_valid <= id_valid & ~w_dec_illegal;
                // Tags only matter for writers; keep them clear otherwise.
                r_ex_dst   <= w_id_ctrl.ex.reg_write ? w_id_dst : '0;
            end
            r_mem_read      <= r_ex.mem_read;
            r_mem_write     <= r_ex.mem_write;
            r_mem_to_reg    <= r_ex.mem_to_reg;
            r_mem_reg_write <= r_ex.reg_write;
            r_mem_dst       <= r_ex_dst;
            r_wb_mem_to_reg <= r_mem_to_reg;
            r_wb_reg_write  <= r_mem_reg_write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_hz && !ext_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_redirect && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign id_rt_is_source = w_dec_ctrl.rt_is_source;
    assign id_illegal      = id_valid & w_dec_illegal;
    assign ex_valid        = r_ex_valid;
    assign ex_imm_command  = r_ex.imm_command;
    assign ex_alu_src_b    = r_ex.alu_src_b;
    assign ex_dst_reg_sel  = r_ex.dst_sel;
    assign ex_alu_op       = ALU_OP_W'(r_ex.alu_op);
    assign ex_link         = r_ex.link;
    assign mem_read        = r_mem_read;
    assign mem_write       = r_mem_write;
    assign wb_mem_to_reg   = r_wb_mem_to_reg;
    assign wb_reg_write    = r_wb_reg_write;
    assign stall_cnt       = r_stall_cnt;
    assign flush_cnt       = r_flush_cnt;

    // The mem-to-reg flag only needs to reach WB; MEM reg_write feeds WB too.
    // Nothing else in MEM is observed here.

endmodule
